mac_operand_feeder: RTL and testbench
=====================================

// Module: mac_operand_feeder
// PURPOSE
//  Drives the operand side of the MAC: on start, clears the accumulator, then reads
//  VEC_LEN element pairs from two synchronous operand RAMs (1-cycle read latency).
//  Streams each pair to the MAC with a one-cycle enable, then captures the final
//  accumulated sum and pulses done.
//  Sits between the operand RAMs and one MAC instance; computes one dot product per start.
// PARAMETERS
//  DATA_WIDTH  8  operand width; the MAC output is 3*DATA_WIDTH.
//  VEC_LEN     8  element pairs per dot product; 1 <= VEC_LEN <= 2**ADDR_WIDTH.
//  ADDR_WIDTH  3  operand RAM address width.
// PORTS
//  clk           in   1             system clock, rising edge.
//  rst           in   1             asynchronous, active-high reset.
//  start         in   1             request a dot product; sampled in IDLE or DONE only.
//  busy          out  1             high from the cycle after an accepted start until done.
//  done          out  1             one-cycle pulse; result valid from this cycle on.
//  result        out  3*DATA_WIDTH  captured dot product; held until the next capture.
//  rd_en         out  1             read strobe to both operand RAMs.
//  rd_addr       out  ADDR_WIDTH    element index, shared by the A and B RAMs.
//  a_rdata       in   DATA_WIDTH    A RAM data, valid the cycle after rd_en.
//  b_rdata       in   DATA_WIDTH    B RAM data, valid the cycle after rd_en.
//  mac_en        out  1             MAC accumulate enable.
//  mac_clr       out  1             MAC synchronous clear.
//  mac_ain       out  DATA_WIDTH    MAC operand A.
//  mac_bin       out  DATA_WIDTH    MAC operand B.
//  mac_cout      in   3*DATA_WIDTH  MAC accumulator value.
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0, state IDLE, counters 0, result 0.
//  FSM states: IDLE, CLEAR, READ, DRAIN, CAPTURE, DONE.
//   IDLE   : start=1 -> CLEAR; otherwise stay.
//   CLEAR  : mac_clr=1 for exactly one cycle -> READ. Address counter <= 0.
//   READ   : rd_en=1 and rd_addr=k for k = 0..VEC_LEN-1 on consecutive cycles.
//            After k = VEC_LEN-1 -> DRAIN.
//   DRAIN  : one cycle; returns the last RAM word -> CAPTURE.
//   CAPTURE: mac_en=0; result <= mac_cout at the end of this cycle -> DONE.
//   DONE   : done=1 for one cycle; start=1 -> CLEAR (back-to-back run); otherwise -> IDLE.
//  mac_en is rd_en delayed one cycle by a register: high for exactly VEC_LEN consecutive
//  cycles, each aligned with the RAM data for one index.
//  mac_ain = mac_en ? a_rdata : 0; mac_bin = mac_en ? b_rdata : 0 (combinational).
//  mac_clr and mac_en are never high in the same cycle.
//  Timing (start sampled in cycle 0):
//   mac_clr in cycle 1; rd_en in cycles 2..VEC_LEN+1; mac_en in cycles 3..VEC_LEN+2;
//   CAPTURE in cycle VEC_LEN+3; done and valid result in cycle VEC_LEN+4.
//  busy=1 in CLEAR, READ, DRAIN and CAPTURE; busy=0 in IDLE and DONE.
//  start while busy is ignored; no queueing.
//  Width: result is a straight copy of mac_cout. With VEC_LEN <= 2**DATA_WIDTH the
//   accumulated sum fits in 3*DATA_WIDTH bits; a wider VEC_LEN wraps modulo 2**(3*DATA_WIDTH).
//  Reset mid-operation: immediate return to IDLE; mac_en/mac_clr/rd_en drop in the same
//   cycle; result is cleared to 0; no done pulse. The next start runs normally (CLEAR first).
// TESTING
//  1. A[i]=i+1, B[i]=1, VEC_LEN=8; start in cycle 0 -> result=36, done only in cycle 12,
//     busy high in cycles 1..11.
//  2. A and B all 8'hFF -> result=24'd520200; mac_en high for exactly 8 cycles;
//     mac_clr high only in cycle 1.
//  3. Hold start=1 through the DONE cycle with new RAM contents (all 2s) -> second run
//     begins with mac_clr; result=32, with no carry-over from run 1.
//  4. Pulse start in cycles 4 and 7 of a run -> ignored; exactly one done, at cycle 12.
//  5. Assert rst in cycle 6 of a run -> all outputs 0 in that cycle, no done; a new start
//     yields the correct result 12 cycles later.
//  6. VEC_LEN=1, A[0]=7, B[0]=9 -> single rd_en and single mac_en; result=63;
//     done at cycle 5.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand feeder for a single MAC: clears the accumulator, streams VEC_LEN element
// pairs from two 1-cycle-latency RAMs, then captures the dot product and pulses done.
module mac_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [3*DATA_WIDTH-1:0] result,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VEC_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, CAPTURE, DONE} state_t;

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      // mac_en trails rd_en by one cycle so it lines up with the RAM read data
      mac_en  <= rd_en;
      done    <= 1'b0;
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= READ;
          rd_en   <= 1'b1;
          rd_addr <= '0;
        end
        READ: begin
          if (rd_addr == LAST_ADDR) begin
            state   <= DRAIN;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          result <= mac_cout;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          if (start) begin
            state   <= CLEAR;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mac_ain = mac_en ? a_rdata : '0;
  assign mac_bin = mac_en ? b_rdata : '0;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: RAM and MAC models around two instances
// (VEC_LEN=8 and VEC_LEN=1), per-cycle control checks and a result scoreboard.
module tb_mac_operand_feeder;

  localparam int RW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic          busy0, done0, rd_en0, mac_en0, mac_clr0;
  logic          busy1, done1, rd_en1, mac_en1, mac_clr1;
  logic [RW-1:0] result0, result1;
  logic [2:0]    rd_addr0, rd_addr1;
  logic [7:0]    a_rdata0 = '0, b_rdata0 = '0, a_rdata1 = '0, b_rdata1 = '0;
  logic [7:0]    mac_ain0, mac_bin0, mac_ain1, mac_bin1;
  logic [RW-1:0] mac_cout0 = '0, mac_cout1 = '0;

  logic [7:0] ma0 [8];
  logic [7:0] mb0 [8];
  logic [7:0] ma1 [8];
  logic [7:0] mb1 [8];

  mac_operand_feeder #(.DATA_WIDTH(8), .VEC_LEN(8), .ADDR_WIDTH(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .result(result0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .a_rdata(a_rdata0), .b_rdata(b_rdata0),
    .mac_en(mac_en0), .mac_clr(mac_clr0), .mac_ain(mac_ain0), .mac_bin(mac_bin0),
    .mac_cout(mac_cout0)
  );

  mac_operand_feeder #(.DATA_WIDTH(8), .VEC_LEN(1), .ADDR_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .result(result1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .a_rdata(a_rdata1), .b_rdata(b_rdata1),
    .mac_en(mac_en1), .mac_clr(mac_clr1), .mac_ain(mac_ain1), .mac_bin(mac_bin1),
    .mac_cout(mac_cout1)
  );

  // Synchronous RAMs (1-cycle latency) and accumulating MACs
  always @(posedge clk) begin
    if (rd_en0) begin
      a_rdata0 <= ma0[rd_addr0];
      b_rdata0 <= mb0[rd_addr0];
    end
    if (rd_en1) begin
      a_rdata1 <= ma1[rd_addr1];
      b_rdata1 <= mb1[rd_addr1];
    end
    if (mac_clr0)     mac_cout0 <= '0;
    else if (mac_en0) mac_cout0 <= mac_cout0 + RW'(mac_ain0) * RW'(mac_bin0);
    if (mac_clr1)     mac_cout1 <= '0;
    else if (mac_en1) mac_cout1 <= mac_cout1 + RW'(mac_ain1) * RW'(mac_bin1);
  end

  int total = 0;
  int bad = 0;
  logic [RW-1:0] sbq [$];

  typedef struct {
    int a_base;
    int a_step;
    int b_base;
    int b_step;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // {mac_clr, rd_en, rd_addr, mac_en, busy, done, mac_ain, mac_bin}
  function automatic logic [RW-1:0] sample(input bit sel);
    if (sel) return {mac_clr1, rd_en1, rd_addr1, mac_en1, busy1, done1, mac_ain1, mac_bin1};
    return {mac_clr0, rd_en0, rd_addr0, mac_en0, busy0, done0, mac_ain0, mac_bin0};
  endfunction

  function automatic logic [RW-1:0] expect_vec(input bit sel, input int len, input int c);
    logic       clr, rd, en, bsy, dn;
    logic [2:0] addr;
    logic [7:0] ain, bin;
    clr  = (c == 1);
    rd   = (c >= 2) && (c <= len + 1);
    addr = rd ? 3'(c - 2) : 3'd0;
    en   = (c >= 3) && (c <= len + 2);
    bsy  = (c >= 1) && (c <= len + 3);
    dn   = (c == len + 4);
    ain  = '0;
    bin  = '0;
    if (en) begin
      ain = sel ? ma1[c-3] : ma0[c-3];
      bin = sel ? mb1[c-3] : mb0[c-3];
    end
    return {clr, rd, addr, en, bsy, dn, ain, bin};
  endfunction

  // Called just after start is raised in cycle 0; checks cycles 1..len+4 (+1 idle cycle)
  task automatic run_checks(input bit sel, input int len, input bit keep, input int pa, input int pb);
    int  last;
    bit  sv;
    last = keep ? len + 4 : len + 5;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check($sformatf("cyc%0d", c), sample(sel), expect_vec(sel, len, c));
      if (sel ? done1 : done0) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got done with no expected result queued");
        end else begin
          check("result", sel ? result1 : result0, sbq.pop_front());
        end
      end
      sv = keep || (c == pa) || (c == pb);
      if (sel) start1 = sv;
      else     start0 = sv;
    end
  endtask

  task automatic load0(input int ab, input int as, input int bb, input int bs);
    for (int i = 0; i < 8; i++) begin
      ma0[i] = 8'(ab + as * i);
      mb0[i] = 8'(bb + bs * i);
    end
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 0, 24'd36};
    tbl[1] = '{255, 0, 255, 0, 24'd520200};
    tbl[2] = '{2, 0, 2, 0, 24'd32};
    tbl[3] = '{0, 1, 3, 0, 24'd84};
    tbl[4] = '{10, 5, 2, 0, 24'd440};
    load0(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      ma1[i] = '0;
      mb1[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst0_ctl", sample(0), '0);
    check("rst0_result", result0, '0);
    check("rst1_ctl", sample(1), '0);
    rst = 1'b0;

    // Table-driven runs
    for (int t = 0; t < 5; t++) begin
      load0(tbl[t].a_base, tbl[t].a_step, tbl[t].b_base, tbl[t].b_step);
      @(negedge clk);
      sbq.push_back(tbl[t].exp);
      start0 = 1'b1;
      run_checks(0, 8, 0, -1, -1);
    end

    // Back-to-back: start held through DONE, new RAM contents for run 2
    load0(1, 1, 1, 0);
    @(negedge clk);
    sbq.push_back(24'd36);
    start0 = 1'b1;
    run_checks(0, 8, 1, -1, -1);
    load0(2, 0, 2, 0);
    sbq.push_back(24'd32);
    run_checks(0, 8, 0, -1, -1);

    // Start pulses while busy are ignored
    load0(1, 1, 1, 0);
    @(negedge clk);
    sbq.push_back(24'd36);
    start0 = 1'b1;
    run_checks(0, 8, 0, 4, 7);

    // Reset in cycle 6 of a run
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_ctl", sample(0), '0);
    check("midrst_result", result0, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst%0d", c), sample(0), '0);
    end
    sbq.push_back(24'd36);
    start0 = 1'b1;
    run_checks(0, 8, 0, -1, -1);

    // VEC_LEN = 1
    ma1[0] = 8'd7;
    mb1[0] = 8'd9;
    @(negedge clk);
    sbq.push_back(24'd63);
    start1 = 1'b1;
    run_checks(1, 1, 0, -1, -1);

    check("sb_drained", RW'(sbq.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
